// File: rtl/ram_loader.sv
`timescale 1ns/1ps
// ram_loader: packs ASCII hex characters MSB-first into DATA_W-bit words and writes them to RAM from
// address 0, flagging load_done when complete. `define RAM_LOADER_NIBBLE_CNT_EN adds nibble_count.
module ram_loader #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 64,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              resetB,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              ramloader_ceb,
  output logic              ramloader_web,
  output logic [ADDR_W-1:0] ramloader_addr,
  output logic [DATA_W-1:0] ramloader_wdata,
  input  logic [ADDR_W-1:0] good_addr,
  output logic              load_done,
  output logic              err_overflow,
  output logic              err_timeout
`ifdef RAM_LOADER_NIBBLE_CNT_EN
  ,
  output logic [ADDR_W+$clog2(DATA_W/4):0] nibble_count
`endif
);

  localparam int NIB = DATA_W / 4;
  localparam int NW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [2:0] {IDLE, FILL, WRITE, WAIT_ACK, DONE} state_t;

  state_t            state, state_nxt;
  logic              rdy_nxt, ceb_nxt, web_nxt, done_nxt, ovf_nxt, to_nxt;
  logic [ADDR_W-1:0] addr_nxt, addr_inc;
  logic [DATA_W-1:0] wdata_nxt;
  logic [NW-1:0]     nib_cnt, nib_nxt;
  logic              last, last_nxt, full, full_nxt;
  logic [7:0]        tcnt, tcnt_nxt;
  logic              is_hex;
  logic [3:0]        nib_val;
  int unsigned       shamt;
`ifdef RAM_LOADER_NIBBLE_CNT_EN
  logic [ADDR_W+$clog2(DATA_W/4):0] cnt_nxt;
`endif

  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    r = '0;
    if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, 4'(c - 8'h30)};
    else if (c >= 8'h41 && c <= 8'h46) r = {1'b1, 4'(c - 8'h37)};
    else if (c >= 8'h61 && c <= 8'h66) r = {1'b1, 4'(c - 8'h57)};
    return r;
  endfunction

  assign {is_hex, nib_val} = hex_decode(rx_data);
  assign addr_inc = ramloader_addr + 1'b1;

  always_comb begin
    state_nxt = state;
    rdy_nxt   = rx_ready;
    ceb_nxt   = ramloader_ceb;
    web_nxt   = ramloader_web;
    addr_nxt  = ramloader_addr;
    wdata_nxt = ramloader_wdata;
    nib_nxt   = nib_cnt;
    last_nxt  = last;
    full_nxt  = full;
    tcnt_nxt  = tcnt;
    done_nxt  = load_done;
    ovf_nxt   = err_overflow;
    to_nxt    = err_timeout;
`ifdef RAM_LOADER_NIBBLE_CNT_EN
    cnt_nxt   = nibble_count;
`endif
    shamt     = unsigned'(4 * (NIB - 1 - int'(nib_cnt)));
    case (state)
      IDLE, FILL: begin
        rdy_nxt = 1'b1;
        if (rx_valid && rx_ready) begin
          if (is_hex) begin
            if (full) begin
              ovf_nxt = 1'b1;
            end else begin
              // the target nibble is always zero here, so OR-ing places it
              wdata_nxt = ramloader_wdata | (DATA_W'(nib_val) << shamt);
`ifdef RAM_LOADER_NIBBLE_CNT_EN
              if (nibble_count != '1) cnt_nxt = nibble_count + 1'b1;
`endif
              if (nib_cnt == NW'(NIB - 1)) begin
                state_nxt = WRITE;
                rdy_nxt   = 1'b0;
                ceb_nxt   = 1'b0;
                web_nxt   = 1'b0;
              end else begin
                nib_nxt   = nib_cnt + 1'b1;
                state_nxt = FILL;
              end
            end
          end else if (state == FILL) begin
            rdy_nxt = 1'b0;
            if (nib_cnt == '0) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
            end else begin
              last_nxt  = 1'b1;
              state_nxt = WRITE;
              ceb_nxt   = 1'b0;
              web_nxt   = 1'b0;
            end
          end
        end
      end
      WRITE: begin
        ceb_nxt   = 1'b1;
        web_nxt   = 1'b1;
        tcnt_nxt  = '0;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (good_addr == addr_inc) begin
          addr_nxt  = addr_inc;
          wdata_nxt = '0;
          nib_nxt   = '0;
          if (ramloader_addr == '1) full_nxt = 1'b1;
          if (last) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = FILL;
            rdy_nxt   = 1'b1;
          end
        end else if (tcnt == 8'(ACK_TIMEOUT - 1)) begin
          to_nxt    = 1'b1;
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end else begin
          tcnt_nxt = tcnt + 1'b1;
        end
      end
      DONE: ;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetB) begin
    if (!resetB) begin
      state           <= IDLE;
      rx_ready        <= 1'b0;
      ramloader_ceb   <= 1'b1;
      ramloader_web   <= 1'b1;
      ramloader_addr  <= '0;
      ramloader_wdata <= '0;
      nib_cnt         <= '0;
      last            <= 1'b0;
      full            <= 1'b0;
      tcnt            <= '0;
      load_done       <= 1'b0;
      err_overflow    <= 1'b0;
      err_timeout     <= 1'b0;
`ifdef RAM_LOADER_NIBBLE_CNT_EN
      nibble_count    <= '0;
`endif
    end else begin
      state           <= state_nxt;
      rx_ready        <= rdy_nxt;
      ramloader_ceb   <= ceb_nxt;
      ramloader_web   <= web_nxt;
      ramloader_addr  <= addr_nxt;
      ramloader_wdata <= wdata_nxt;
      nib_cnt         <= nib_nxt;
      last            <= last_nxt;
      full            <= full_nxt;
      tcnt            <= tcnt_nxt;
      load_done       <= done_nxt;
      err_overflow    <= ovf_nxt;
      err_timeout     <= to_nxt;
`ifdef RAM_LOADER_NIBBLE_CNT_EN
      nibble_count    <= cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
`timescale 1ns/1ps
// Bench for ram_loader: character streams scored against a string-level packing model, with a
// ram_controller stand-in that commits each write after a programmable delay (or never).
module tb_ram_loader;
  localparam int ADDR_W      = 10;
  localparam int DATA_W      = 64;
  localparam int ACK_TIMEOUT = 255;
  localparam int NWORDS      = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              resetB = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_ready, ramloader_ceb, ramloader_web;
  logic [ADDR_W-1:0] ramloader_addr;
  logic [DATA_W-1:0] ramloader_wdata;
  logic [ADDR_W-1:0] good_addr = '0;
  logic              load_done, err_overflow, err_timeout;
`ifdef RAM_LOADER_NIBBLE_CNT_EN
  logic [ADDR_W+$clog2(DATA_W/4):0] nibble_count;
`endif

  always #5 clk = ~clk;

  ram_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .resetB(resetB), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .ramloader_ceb(ramloader_ceb), .ramloader_web(ramloader_web), .ramloader_addr(ramloader_addr),
    .ramloader_wdata(ramloader_wdata), .good_addr(good_addr), .load_done(load_done),
    .err_overflow(err_overflow), .err_timeout(err_timeout)
`ifdef RAM_LOADER_NIBBLE_CNT_EN
    , .nibble_count(nibble_count)
`endif
  );

  typedef struct {logic [ADDR_W-1:0] a; logic [63:0] d;} wr_t;
  wr_t exp_q[$];
  byte stim[$];
  int  n_chk, n_fail;
  bit  exp_ovf;
  int  exp_cnt;
  int  n_writes, ack_delay, cd, cyc, t_write, t_to;
  bit  freeze, cd_active, prev_low, to_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int hexval(input byte c);
    int ci;
    ci = int'(c);
    if (ci >= 48 && ci <= 57)  return ci - 48;
    if (ci >= 65 && ci <= 70)  return ci - 55;
    if (ci >= 97 && ci <= 102) return ci - 87;
    return -1;
  endfunction

  // Expected RAM image: hex chars concatenated 16 per word, last word zero-padded, stop at first terminator.
  function automatic void build_model();
    logic [63:0] w;
    int nib, nw, v;
    bit started, full;
    w = '0; nib = 0; nw = 0; started = 0; full = 0;
    exp_q.delete(); exp_ovf = 0; exp_cnt = 0;
    foreach (stim[i]) begin
      v = hexval(stim[i]);
      if (v >= 0) begin
        started = 1;
        if (full) exp_ovf = 1;
        else begin
          w[63-4*nib -: 4] = 4'(v);
          nib++; exp_cnt++;
          if (nib == 16) begin
            exp_q.push_back('{a: ADDR_W'(nw % NWORDS), d: w});
            nw++; w = '0; nib = 0;
            if (nw == NWORDS) full = 1;
          end
        end
      end else if (started) begin
        if (nib > 0) exp_q.push_back('{a: ADDR_W'(nw % NWORDS), d: w});
        break;
      end
    end
  endfunction

  function automatic void push_str(input string s);
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
  endfunction

  function automatic void gen_random();
    string hx;
    int nhex;
    hx = "0123456789abcdefABCDEF";
    stim.delete();
    if ($urandom_range(1) == 1) stim.push_back(8'h20);
    nhex = ($urandom_range(3) == 0) ? 16 * int'($urandom_range(1, 2)) : int'($urandom_range(1, 40));
    for (int i = 0; i < nhex; i++) stim.push_back(hx[$urandom_range(21)]);
    case ($urandom_range(2))
      0:       stim.push_back(8'h0A);
      1:       stim.push_back(8'h20);
      default: stim.push_back(8'h2C);
    endcase
  endfunction

  // Scoreboard plus ram_controller stand-in; compare first, then advance the commit model.
  always @(negedge clk) begin
    if (!resetB) begin
      good_addr = '0; cd_active = 0; prev_low = 0;
    end else begin
      cyc++;
      if (ramloader_ceb === 1'b0) begin
        n_writes++; t_write = cyc;
        chk("write_web", 64'(ramloader_web), 64'd0);
        chk("write_single_cycle", 64'(prev_low), 64'd0);
        chk("ready_during_write", 64'(rx_ready), 64'd0);
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL extra_write: write %0d at addr %h, expected no write", n_writes, ramloader_addr);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_addr", 64'(ramloader_addr), 64'(e.a));
          chk("write_data", ramloader_wdata, e.d);
        end
      end
      if (cd_active) chk("ready_in_wait", 64'(rx_ready), 64'd0);
      if (err_timeout === 1'b1 && !to_seen) begin to_seen = 1; t_to = cyc; end
      prev_low = (ramloader_ceb === 1'b0);
      if (ramloader_ceb === 1'b0) begin
        cd_active = 1; cd = ack_delay;
      end else if (cd_active && !freeze) begin
        if (cd == 0) begin good_addr = good_addr + 1'b1; cd_active = 0; end
        else cd--;
      end
    end
  end

  task automatic do_reset(input int delay, input bit frz);
    @(negedge clk);
    rx_valid = 0; resetB = 0;
    ack_delay = delay; freeze = frz; to_seen = 0; n_writes = 0; exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic send_stream(input bit gaps);
    int w;
    foreach (stim[i]) begin
      if (gaps && $urandom_range(3) == 0) begin
        @(negedge clk); rx_valid = 0; rx_data = 8'($urandom);
      end
      @(negedge clk); rx_valid = 1; rx_data = stim[i];
      w = 0;
      while (!rx_ready && w < 400) begin @(negedge clk); w++; end
      if (w >= 400) begin
        n_chk++; n_fail++;
        $display("FAIL rx_handshake: char %0d never accepted, rx_ready=%b expected 1", i, rx_ready);
        break;
      end
      @(posedge clk);
    end
    @(negedge clk); rx_valid = 0;
  endtask

  task automatic finish_check(input string tag, input bit frz);
    int w;
    w = 0;
    while (load_done !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
    chk({tag, "_load_done"}, 64'(load_done), 64'd1);
    repeat (4) @(negedge clk);
    chk({tag, "_writes_left"}, 64'(exp_q.size()), 64'd0);
    chk({tag, "_err_overflow"}, 64'(err_overflow), 64'(exp_ovf));
    chk({tag, "_err_timeout"}, 64'(err_timeout), 64'(frz));
    chk({tag, "_ceb_idle"}, 64'(ramloader_ceb), 64'd1);
    chk({tag, "_ready_done"}, 64'(rx_ready), 64'd0);
`ifdef RAM_LOADER_NIBBLE_CNT_EN
    chk({tag, "_nibble_count"}, 64'(nibble_count), 64'(exp_cnt));
`endif
    if (frz) chk({tag, "_timeout_cycles"}, 64'(t_to - t_write), 64'd256);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    #1 resetB = 0;
    #10;
    chk("rst_rx_ready", 64'(rx_ready), 64'd0);
    chk("rst_ceb", 64'(ramloader_ceb), 64'd1);
    chk("rst_web", 64'(ramloader_web), 64'd1);
    chk("rst_addr", 64'(ramloader_addr), 64'd0);
    chk("rst_wdata", ramloader_wdata, 64'd0);
    chk("rst_flags", 64'({load_done, err_overflow, err_timeout}), 64'd0);
    @(negedge clk); resetB = 1;
    @(negedge clk);
    chk("ready_after_reset", 64'(rx_ready), 64'd1);

    do_reset(0, 0);
    stim.delete(); push_str("D2FE28\n"); build_model();
    chk("model_d2fe28_n", 64'(exp_q.size()), 64'd1);
    chk("model_d2fe28", exp_q[0].d, 64'hD2FE280000000000);
    chk("model_d2fe28_cnt", 64'(exp_cnt), 64'd6);
    resetB = 1; send_stream(0); finish_check("d2fe28", 0);

    do_reset($urandom_range(3), 0);
    stim.delete(); push_str("0123456789abcdefFEDCBA9876543210\n"); build_model();
    chk("model_two_n", 64'(exp_q.size()), 64'd2);
    chk("model_two_w0", exp_q[0].d, 64'h0123456789ABCDEF);
    chk("model_two_w1", exp_q[1].d, 64'hFEDCBA9876543210);
    resetB = 1; send_stream(1); finish_check("two_words", 0);

    do_reset(10, 0);
    gen_random(); build_model();
    resetB = 1; send_stream(1); finish_check("ack_delay10", 0);

    do_reset(0, 1);
    stim.delete(); push_str("12\n"); build_model();
    resetB = 1; send_stream(0); finish_check("timeout", 1);

    for (int k = 0; k < 10; k++) begin
      do_reset($urandom_range(4), 0);
      gen_random(); build_model();
      resetB = 1; send_stream(1); finish_check("random", 0);
    end

    do_reset(0, 0);
    stim.delete(); push_str("12345"); build_model();
    resetB = 1; send_stream(0);
    @(negedge clk); resetB = 0;
    #1;
    chk("midrst_ceb", 64'(ramloader_ceb), 64'd1);
    chk("midrst_wdata", ramloader_wdata, 64'd0);
    chk("midrst_ready", 64'(rx_ready), 64'd0);
    repeat (2) @(negedge clk);
    stim.delete(); push_str("A\n"); build_model();
    chk("model_midrst", exp_q[0].d, 64'hA000000000000000);
    resetB = 1; send_stream(0); finish_check("midrst", 0);

    do_reset(0, 0);
    stim.delete();
    for (int i = 0; i < 16 * NWORDS + 1; i++) stim.push_back(8'h46);
    stim.push_back(8'h0A);
    build_model();
    chk("model_full_n", 64'(exp_q.size()), 64'(NWORDS));
    chk("model_full_ovf", 64'(exp_ovf), 64'd1);
    resetB = 1; send_stream(0); finish_check("overflow", 0);
    chk("overflow_addr_wrap", 64'(ramloader_addr), 64'd0);
    chk("overflow_writes", 64'(n_writes), 64'(NWORDS));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
